// File: rtl/bu_exec.sv
// bu_exec - branch execution unit
//
// Accepts one branch/jump per cycle from the branch reservation station,
// reads its operands from the PRF, resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR
// and holds the result in an output register until the CDB/ROB grants it.
// There is no predictor: every redirect (taken branch or jump) is reported as a
// mispredict.
//
// Pipeline: S1 holds the captured issue fields while the PRF data arrives,
// and the result is computed there. S2 is the output register.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   valid_in / fu_rdy   issue handshake (fires on valid_in & fu_rdy)
//   in_*                issue fields: pc, opcode, func3, imm, prd, pr1, pr2, rob index
//   pr1/pr2_addr/data   PRF read port; data returns the cycle after the address
//   out_valid / out_ack result handshake (retires on out_valid & out_ack)
//   cdb_we/tag/data     link-register write and wakeup broadcast
//   rob_index           completing ROB slot
//   mispredict          redirect required; redirect_pc is the correct next PC
//   flush               kills all in-flight work, wins over out_ack and issue
//
// Optional feature (macro BU_PERF_CNT_EN): adds perf_br_cnt and
// perf_mispred_cnt, saturating retire / mispredicted-retire counters that are
// cleared by reset only.
module bu_exec #(
    parameter int XLEN   = 32,
    parameter int PREG_W = 7,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              fu_rdy,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_func3,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [PREG_W-1:0] in_prd,
    input  logic [PREG_W-1:0] in_pr1,
    input  logic [PREG_W-1:0] in_pr2,
    input  logic [ROB_W-1:0]  in_rob_index,
    output logic [PREG_W-1:0] pr1_addr,
    output logic [PREG_W-1:0] pr2_addr,
    input  logic [XLEN-1:0]   pr1_data,
    input  logic [XLEN-1:0]   pr2_data,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              cdb_we,
    output logic [PREG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]   cdb_data,
    output logic [ROB_W-1:0]  rob_index,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              flush
`ifdef BU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_br_cnt,
    output logic [31:0]       perf_mispred_cnt
`endif
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic cond_taken(input logic [2:0] f3,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  cond_taken = (a == b);
            3'b001:  cond_taken = (a != b);
            3'b100:  cond_taken = (sa < sb);
            3'b101:  cond_taken = (sa >= sb);
            3'b110:  cond_taken = (a < b);
            3'b111:  cond_taken = (a >= b);
            default: cond_taken = 1'b0;
        endcase
    endfunction

    logic              s1_valid;
    logic              s1_fresh;
    logic              s2_valid;
    logic [XLEN-1:0]   s1_pc;
    logic [XLEN-1:0]   s1_imm;
    logic [6:0]        s1_opcode;
    logic [2:0]        s1_func3;
    logic [PREG_W-1:0] s1_prd;
    logic [ROB_W-1:0]  s1_rob;
    logic [XLEN-1:0]   op1_q;
    logic [XLEN-1:0]   op2_q;

    logic              issue;
    logic              move;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic              taken;
    logic              wr_link;
    logic [XLEN-1:0]   link;
    logic [XLEN-1:0]   next_pc;

    logic              s2_we;
    logic              s2_mp;

    assign fu_rdy   = !flush && (!s1_valid || !s2_valid || out_ack);
    assign issue    = valid_in && fu_rdy;
    assign move     = s1_valid && (!s2_valid || out_ack);
    assign pr1_addr = in_pr1;
    assign pr2_addr = in_pr2;

    // PRF data is only valid the cycle after issue; later cycles of a stalled
    // S1 use the copy captured then, since the read address tracks the next issue.
    assign op1 = s1_fresh ? pr1_data : op1_q;
    assign op2 = s1_fresh ? pr2_data : op2_q;

    always_comb begin
        taken   = 1'b0;
        wr_link = 1'b0;
        link    = s1_pc + XLEN'(4);
        next_pc = link;
        case (s1_opcode)
            OP_JAL: begin
                taken   = 1'b1;
                wr_link = (s1_prd != '0);
                next_pc = s1_pc + s1_imm;
            end
            OP_JALR: begin
                taken   = 1'b1;
                wr_link = (s1_prd != '0);
                next_pc = (op1 + s1_imm) & {{(XLEN-1){1'b1}}, 1'b0};
            end
            OP_BRANCH: begin
                taken = cond_taken(s1_func3, op1, op2);
                if (taken) next_pc = s1_pc + s1_imm;
            end
            default: ;
        endcase
    end

    // ---- S1: issue capture ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_fresh <= 1'b0;
        end else begin
            s1_fresh <= issue;
            if (flush)      s1_valid <= 1'b0;
            else if (issue) s1_valid <= 1'b1;
            else if (move)  s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            s1_pc     <= in_pc;
            s1_imm    <= in_imm;
            s1_opcode <= in_opcode;
            s1_func3  <= in_func3;
            s1_prd    <= in_prd;
            s1_rob    <= in_rob_index;
        end
        if (s1_fresh) begin
            op1_q <= pr1_data;
            op2_q <= pr2_data;
        end
    end

    // ---- S2: output register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid    <= 1'b0;
            s2_we       <= 1'b0;
            s2_mp       <= 1'b0;
            cdb_tag     <= '0;
            cdb_data    <= '0;
            rob_index   <= '0;
            redirect_pc <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (move) begin
            s2_valid    <= 1'b1;
            s2_we       <= wr_link;
            s2_mp       <= taken;
            cdb_tag     <= s1_prd;
            cdb_data    <= link;
            rob_index   <= s1_rob;
            redirect_pc <= next_pc;
        end else if (out_ack) begin
            s2_valid <= 1'b0;
        end
    end

    // Qualified so a stale result never wakes up consumers or redirects fetch.
    assign out_valid  = s2_valid;
    assign cdb_we     = s2_valid && s2_we;
    assign mispredict = s2_valid && s2_mp;

`ifdef BU_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic retire;
    assign retire = s2_valid && out_ack && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_br_cnt      <= '0;
            perf_mispred_cnt <= '0;
        end else if (retire) begin
            perf_br_cnt <= sat_inc(perf_br_cnt);
            if (s2_mp) perf_mispred_cnt <= sat_inc(perf_mispred_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_bu_exec.sv
module tb_bu_exec;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        fu_rdy;
    logic [31:0] in_pc;
    logic [6:0]  in_opcode;
    logic [2:0]  in_func3;
    logic [31:0] in_imm;
    logic [6:0]  in_prd, in_pr1, in_pr2;
    logic [3:0]  in_rob_index;
    logic [6:0]  pr1_addr, pr2_addr;
    logic [31:0] pr1_data, pr2_data;
    logic        out_valid;
    logic        out_ack;
    logic        cdb_we;
    logic [6:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [3:0]  rob_index;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BU_PERF_CNT_EN
    logic [31:0] perf_br_cnt, perf_mispred_cnt;
`endif

    bu_exec dut (
        .clk(clk), .reset(rst_n), .valid_in(valid_in), .fu_rdy(fu_rdy),
        .in_pc(in_pc), .in_opcode(in_opcode), .in_func3(in_func3), .in_imm(in_imm),
        .in_prd(in_prd), .in_pr1(in_pr1), .in_pr2(in_pr2), .in_rob_index(in_rob_index),
        .pr1_addr(pr1_addr), .pr2_addr(pr2_addr), .pr1_data(pr1_data), .pr2_data(pr2_data),
        .out_valid(out_valid), .out_ack(out_ack), .cdb_we(cdb_we), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .rob_index(rob_index), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .flush(flush)
`ifdef BU_PERF_CNT_EN
        , .perf_br_cnt(perf_br_cnt), .perf_mispred_cnt(perf_mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Physical register file: synchronous read, one cycle after the address.
    logic [31:0] prf [128];
    always @(posedge clk) begin
        pr1_data <= prf[pr1_addr];
        pr2_data <= prf[pr2_addr];
    end

    // Reference model: in-order queue of expected results. 'shown' marks the
    // entry currently presented at the output.
    typedef struct {
        logic        shown;
        logic        we;
        logic [6:0]  tag;
        logic [31:0] link;
        logic [3:0]  rob;
        logic        mp;
        logic [31:0] npc;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_br_cnt = 0;
    logic [31:0] m_mp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ent_t predict(input logic [31:0] pc, input logic [6:0] op,
                                     input logic [2:0] f3, input logic [31:0] imm,
                                     input logic [6:0] prd, input logic [31:0] a,
                                     input logic [31:0] b, input logic [3:0] rob);
        ent_t        e;
        logic        tk;
        logic [31:0] tgt;
        tk  = 1'b0;
        tgt = pc + imm;
        if (op == OP_JAL) tk = 1'b1;
        else if (op == OP_JALR) begin
            tk  = 1'b1;
            tgt = (a + imm) & 32'hFFFF_FFFE;
        end else if (op == OP_BR) begin
            case (f3)
                3'b000: tk = (a == b);
                3'b001: tk = (a != b);
                3'b100: tk = ($signed(a) < $signed(b));
                3'b101: tk = ($signed(a) >= $signed(b));
                3'b110: tk = (a < b);
                3'b111: tk = (a >= b);
                default: tk = 1'b0;
            endcase
        end
        e.shown = 1'b0;
        e.we    = (op == OP_JAL || op == OP_JALR) && prd != 7'd0;
        e.tag   = prd;
        e.link  = pc + 32'd4;
        e.rob   = rob;
        e.mp    = tk;
        e.npc   = tk ? tgt : pc + 32'd4;
        return e;
    endfunction

    task automatic check_outputs(input logic exp_rdy);
        logic exp_ov;
        exp_ov = (q.size() > 0) && q[0].shown;
        check("fu_rdy", fu_rdy, exp_rdy);
        check("out_valid", out_valid, exp_ov);
        check("pr1_addr", pr1_addr, in_pr1);
        check("pr2_addr", pr2_addr, in_pr2);
        if (exp_ov) begin
            check("cdb_we", cdb_we, q[0].we);
            check("rob_index", rob_index, q[0].rob);
            check("mispredict", mispredict, q[0].mp);
            check("redirect_pc", redirect_pc, q[0].npc);
            if (q[0].we) begin
                check("cdb_tag", cdb_tag, q[0].tag);
                check("cdb_data", cdb_data, q[0].link);
            end
        end else begin
            check("cdb_we_idle", cdb_we, 0);
            check("mispredict_idle", mispredict, 0);
        end
`ifdef BU_PERF_CNT_EN
        check("perf_br_cnt", perf_br_cnt, m_br_cnt);
        check("perf_mispred_cnt", perf_mispred_cnt, m_mp_cnt);
`endif
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the model at the edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [6:0] op,
                       input logic [2:0] f3, input logic [31:0] imm, input logic [6:0] prd,
                       input logic [6:0] p1, input logic [6:0] p2, input logic [3:0] rob,
                       input logic ack, input logic fl);
        logic exp_rdy;
        logic accept;
        ent_t e;
        @(negedge clk);
        valid_in = v; in_pc = pc; in_opcode = op; in_func3 = f3; in_imm = imm;
        in_prd = prd; in_pr1 = p1; in_pr2 = p2; in_rob_index = rob;
        out_ack = ack; flush = fl;
        #1;
        exp_rdy = !fl && (q.size() < 2 || ack);
        check_outputs(exp_rdy);
        accept = v && exp_rdy;
        e = predict(pc, op, f3, imm, prd, prf[p1], prf[p2], rob);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (q.size() > 0 && q[0].shown && ack) begin
                m_br_cnt++;
                if (q[0].mp) m_mp_cnt++;
                void'(q.pop_front());
            end
            if (q.size() > 0 && !q[0].shown) q[0].shown = 1'b1;
            if (accept) q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, ack, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) prf[i] = (i % 4 == 0) ? 32'd5 : $urandom;
        prf[1] = 32'd5;        prf[2] = 32'd5;
        prf[3] = 32'd7;        prf[4] = 32'd7;
        prf[5] = 32'hFFFF_FFFF; prf[6] = 32'd1;
        prf[7] = 32'h0000_1001;

        rst_n = 1'b0; valid_in = 0; in_pc = 0; in_opcode = 0; in_func3 = 0; in_imm = 0;
        in_prd = 0; in_pr1 = 0; in_pr2 = 0; in_rob_index = 0; out_ack = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_cdb_we", cdb_we, 0);
        check("rst_mispredict", mispredict, 0);
        check("rst_cdb_tag", cdb_tag, 0);
        check("rst_cdb_data", cdb_data, 0);
        check("rst_rob_index", rob_index, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_fu_rdy", fu_rdy, 1);

        // BEQ equal operands: taken, redirect to 0x108
        cyc(1, 32'h100, OP_BR, 3'b000, 32'd8, 7'd0, 7'd1, 7'd2, 4'd1, 1, 0);
        idle(3, 1);
        // BNE equal: not taken; BLT -1 < 1 taken; BLTU 0xFFFFFFFF < 1 not taken
        cyc(1, 32'h200, OP_BR, 3'b001, 32'd16, 7'd0, 7'd3, 7'd4, 4'd2, 1, 0);
        cyc(1, 32'h210, OP_BR, 3'b100, 32'd32, 7'd0, 7'd5, 7'd6, 4'd3, 1, 0);
        cyc(1, 32'h220, OP_BR, 3'b110, 32'd32, 7'd0, 7'd5, 7'd6, 4'd4, 1, 0);
        idle(3, 1);
        // JALR with and without a link destination
        cyc(1, 32'h300, OP_JALR, 3'b000, 32'd2, 7'd9, 7'd7, 7'd0, 4'd5, 1, 0);
        cyc(1, 32'h400, OP_JALR, 3'b000, 32'd2, 7'd0, 7'd7, 7'd0, 4'd6, 1, 0);
        cyc(1, 32'h500, OP_JAL, 3'b000, 32'hFFFF_FFF0, 7'd12, 7'd0, 7'd0, 4'd7, 1, 0);
        idle(3, 1);
        // Backpressure: three back-to-back issues with no grant, then drain
        cyc(1, 32'h600, OP_BR, 3'b000, 32'd8, 7'd0, 7'd1, 7'd2, 4'd8, 0, 0);
        cyc(1, 32'h604, OP_JAL, 3'b000, 32'd64, 7'd20, 7'd9, 7'd10, 4'd9, 0, 0);
        cyc(1, 32'h608, OP_BR, 3'b001, 32'd8, 7'd0, 7'd3, 7'd4, 4'd10, 0, 0);
        idle(1, 0);
        idle(4, 1);
        // Flush with both stages full and an issue presented
        cyc(1, 32'h700, OP_BR, 3'b000, 32'd8, 7'd0, 7'd1, 7'd2, 4'd11, 0, 0);
        cyc(1, 32'h704, OP_JAL, 3'b000, 32'd8, 7'd21, 7'd0, 7'd0, 4'd12, 0, 0);
        cyc(1, 32'h708, OP_JAL, 3'b000, 32'd8, 7'd22, 7'd0, 7'd0, 4'd13, 1, 1);
        idle(3, 1);

        // Asynchronous reset with work in flight
        cyc(1, 32'h800, OP_BR, 3'b000, 32'd8, 7'd0, 7'd1, 7'd2, 4'd14, 0, 0);
        cyc(1, 32'h804, OP_JAL, 3'b000, 32'd8, 7'd23, 7'd0, 7'd0, 4'd15, 0, 0);
        #2;
        valid_in = 0; flush = 0; out_ack = 0;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_br_cnt = 0;
        m_mp_cnt = 0;
        check("async_out_valid", out_valid, 0);
        check("async_cdb_we", cdb_we, 0);
        check("async_mispredict", mispredict, 0);
`ifdef BU_PERF_CNT_EN
        check("async_perf_br", perf_br_cnt, 0);
        check("async_perf_mp", perf_mispred_cnt, 0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0]  op;
            logic [31:0] r;
            r = $urandom;
            case (r % 8)
                0, 1, 2, 3, 4: op = OP_BR;
                5:             op = OP_JAL;
                6:             op = OP_JALR;
                default:       op = 7'($urandom);
            endcase
            cyc(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, op, 3'($urandom),
                $urandom, 7'($urandom), 7'($urandom), 7'($urandom), 4'($urandom),
                ($urandom % 3) != 0, ($urandom % 25) == 0);
        end
        idle(4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
